// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Sequential instruction fetch with a small prefetch FIFO.
//               Issues word requests to instruction memory under a credit
//               limit, buffers returned words with their PC and hands them to
//               decode over valid/ready. A redirect flushes the queue and
//               discards every response still in flight.
//               Optional macro FETCH_ENCODING_CHECK_EN replaces words whose
//               bits [1:0] are not 2'b11 with a NOP and flags them illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    // instruction memory request
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    // instruction memory response
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    // branch resolution redirect
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    // decode side (out_instruction carries an instruction_type word)
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    localparam int          c_PTR_W = $clog2(DEPTH);
    localparam int          c_CNT_W = c_PTR_W + 1;
    localparam int          c_SUM_W = c_CNT_W + 1;
    localparam logic [31:0] c_NOP   = 32'h0000_0013;
    localparam logic [c_SUM_W-1:0] c_DEPTH_SUM = c_SUM_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("instr_fetch_queue: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [31:0]              r_fetch_pc;
    logic [31:0]              r_rsp_pc;
    logic [c_CNT_W-1:0]       r_inflight;
    logic [c_CNT_W-1:0]       r_drop_cnt;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [DEPTH-1:0][31:0]   r_word;
    logic [DEPTH-1:0][31:0]   r_pc;

    logic [c_SUM_W-1:0]       w_credit_sum;
    logic                     w_req_fire;
    logic                     w_push;
    logic                     w_pop;
    logic [31:0]              w_push_word;
    logic [31:0]              w_redirect_pc;
    logic                     w_unused;

    // Entries already queued plus responses still owed to the queue; the
    // responses that will be dropped do not consume a slot.
    assign w_credit_sum   = c_SUM_W'(r_count) + c_SUM_W'(r_inflight) - c_SUM_W'(r_drop_cnt);
    assign imem_req_valid = (w_credit_sum < c_DEPTH_SUM) && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign out_valid      = (r_count != '0) && !redirect_valid;
    assign w_pop          = out_valid && out_ready;
    assign w_push         = imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);

    assign w_redirect_pc  = {redirect_pc[31:2], 2'b00};
    assign w_unused       = &{1'b0, redirect_pc[1:0]};

    assign out_instruction = r_word[r_rd_ptr];
    assign out_pc          = r_pc[r_rd_ptr];

`ifdef FETCH_ENCODING_CHECK_EN
    logic [DEPTH-1:0] r_ill;
    logic             w_push_ill;

    assign w_push_ill  = (imem_rsp_data[1:0] != 2'b11);
    assign w_push_word = w_push_ill ? c_NOP : imem_rsp_data;
    assign out_illegal = r_ill[r_rd_ptr];

    // Illegal flag storage, written alongside the word and PC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ill <= '0;
        end else if (w_push) begin
            r_ill[r_wr_ptr] <= w_push_ill;
        end
    end
`else
    assign w_push_word = imem_rsp_data;
    assign out_illegal = 1'b0;
`endif

    // Fetch and response PC tracking; a redirect restarts both at the target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

    // Outstanding request count and number of upcoming responses to discard.
    // r_inflight already includes responses that are going to be dropped, so
    // on a redirect the discard count is simply whatever stays in flight
    // after this cycle; repeated redirects therefore never double count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            case ({w_req_fire, imem_rsp_valid})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
            if (redirect_valid) begin
                r_drop_cnt <= r_inflight - c_CNT_W'(imem_rsp_valid);
            end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
            end
        end
    end

    // FIFO occupancy and pointers; a redirect empties the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Word and PC storage for each queue entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_pc   <= '0;
        end else if (w_push) begin
            r_word[r_wr_ptr] <= w_push_word;
            r_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    // The credit limit must keep every accepted response within the queue.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && (r_count == c_DEPTH_CNT)));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. A memory model
//               answers requests in order with configurable latency; a
//               reference model tracks the instruction stream decode should
//               see (requests tagged with a redirect epoch, stale ones are
//               never delivered).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_illegal;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_illegal     (out_illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // stimulus knobs
    int          g_ready_pct  = 100;
    int          g_oready_pct = 100;
    int          g_lat_min    = 1;
    int          g_lat_max    = 1;
    bit          g_redirect   = 1'b0;
    logic [31:0] g_redirect_pc = 32'h0;
    bit          g_zero8      = 1'b0;

    // values sampled in the last cycle
    logic        s_req_valid, s_out_valid, s_out_ill, s_fire, s_pop;
    logic [31:0] s_req_addr, s_out_pc, s_out_instr;

    // reference model
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        int          epoch;
    } mreq_t;
    mreq_t       memq[$];
    logic [31:0] mfifo[$];
    int          epoch = 0;
    int          last_due = 0;
    logic [31:0] exp_req_addr = RESET_PC;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (g_zero8 && a == 32'h8) return 32'h0;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3F ^ {a[15:0], a[31:16]};
    endfunction

    // {illegal, word} that decode should receive for a memory word
    function automatic logic [32:0] exp_out(input logic [31:0] w);
`ifdef FETCH_ENCODING_CHECK_EN
        if (w[1:0] != 2'b11) return {1'b1, 32'h0000_0013};
`endif
        return {1'b0, w};
    endfunction

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic model_reset();
        memq.delete();
        mfifo.delete();
        epoch++;
        last_due     = 0;
        exp_req_addr = RESET_PC;
    endtask

    task automatic set_knobs(input int rp, input int op, input int lmin, input int lmax);
        g_ready_pct  = rp;
        g_oready_pct = op;
        g_lat_min    = lmin;
        g_lat_max    = lmax;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic cycle();
        int          live;
        bit          e_req, e_out;
        mreq_t       r;
        int          lat;
        logic [32:0] e_w;
        @(negedge clk);
        cyc++;
        redirect_valid = g_redirect;
        redirect_pc    = g_redirect_pc;
        imem_req_ready = roll(g_ready_pct);
        out_ready      = roll(g_oready_pct);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_instr = out_instruction;
        s_out_ill   = out_illegal;

        live = 0;
        foreach (memq[i]) if (memq[i].epoch == epoch) live++;
        e_req = !g_redirect && ((mfifo.size() + live) < DEPTH);
        e_out = !g_redirect && (mfifo.size() > 0);

        n_checks++;
        if (s_req_valid !== e_req) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d got=%0b exp=%0b", cyc, s_req_valid, e_req);
        end
        if (e_req) begin
            n_checks++;
            if (s_req_addr !== exp_req_addr) begin
                n_fail++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, s_req_addr, exp_req_addr);
            end
        end
        n_checks++;
        if (s_out_valid !== e_out) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, s_out_valid, e_out);
        end
        if (e_out) begin
            e_w = exp_out(memf(mfifo[0]));
            n_checks += 3;
            if (s_out_pc !== mfifo[0]) begin
                n_fail++;
                $display("FAIL out_pc cyc=%0d got=%h exp=%h", cyc, s_out_pc, mfifo[0]);
            end
            if (s_out_instr !== e_w[31:0]) begin
                n_fail++;
                $display("FAIL out_instruction cyc=%0d got=%h exp=%h", cyc, s_out_instr, e_w[31:0]);
            end
            if (s_out_ill !== e_w[32]) begin
                n_fail++;
                $display("FAIL out_illegal cyc=%0d got=%0b exp=%0b", cyc, s_out_ill, e_w[32]);
            end
        end

        s_fire = s_req_valid && imem_req_ready;
        s_pop  = s_out_valid && out_ready;
        if (s_pop && mfifo.size() > 0) void'(mfifo.pop_front());
        if (imem_rsp_valid) begin
            r = memq.pop_front();
            if (!g_redirect && r.epoch == epoch) mfifo.push_back(r.pc);
        end
        if (g_redirect) begin
            mfifo.delete();
            epoch++;
            exp_req_addr = {g_redirect_pc[31:2], 2'b00};
        end
        if (s_fire) begin
            lat     = $urandom_range(g_lat_max, g_lat_min);
            r.addr  = s_req_addr;
            r.pc    = exp_req_addr;
            r.due   = (cyc + lat > last_due) ? cyc + lat : last_due;
            r.epoch = epoch;
            last_due = r.due;
            memq.push_back(r);
            exp_req_addr = exp_req_addr + 32'd4;
        end
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        g_redirect     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        if (out_instruction !== 32'h0) begin n_fail++; $display("FAIL rst_out_instruction got=%h exp=0", out_instruction); end
        if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
        if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_out_illegal got=%0b exp=0", out_illegal); end
        do_reset();
        set_knobs(100, 100, 1, 1);
        cycle();
        n_checks++;
        if (!(s_req_valid === 1'b1 && s_req_addr === RESET_PC)) begin
            n_fail++;
            $display("FAIL rst_first_req got=%0b/%h exp=1/%h", s_req_valid, s_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        set_knobs(100, 100, 1, 1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i < 3) begin
                n_checks++;
                if (!(s_req_valid === 1'b1 && s_req_addr === 32'(4 * i))) begin
                    n_fail++;
                    $display("FAIL stream_req i=%0d got=%0b/%h exp=1/%h", i, s_req_valid, s_req_addr, 4 * i);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if (!(s_out_valid === 1'b1 && s_out_pc === 32'(4 * (i - 2)))) begin
                    n_fail++;
                    $display("FAIL stream_out i=%0d got=%0b/%h exp=1/%h", i, s_out_valid, s_out_pc, 4 * (i - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          fires;
        bit          got;
        logic [31:0] first_addr;
        do_reset();
        set_knobs(100, 0, 1, 1);
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_fire) fires++;
        end
        n_checks += 2;
        if (fires != DEPTH) begin n_fail++; $display("FAIL bp_req_count got=%0d exp=%0d", fires, DEPTH); end
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled got=%0b exp=0", s_req_valid); end
        g_oready_pct = 100;
        got = 1'b0;
        first_addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_fire && !got) begin got = 1'b1; first_addr = s_req_addr; end
            n_checks++;
            if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pop i=%0d got=%0b exp=1", i, s_out_valid); end
        end
        n_checks++;
        if (!(got && first_addr === 32'h10)) begin
            n_fail++;
            $display("FAIL bp_resume_addr got=%0b/%h exp=1/00000010", got, first_addr);
        end
    endtask

    task automatic test_redirect_stale();
        bit          got;
        int          first_i, stale;
        logic [31:0] first_pc;
        do_reset();
        set_knobs(100, 100, 3, 3);
        repeat (3) cycle();
        g_redirect = 1'b1;
        g_redirect_pc = 32'h100;
        cycle();
        g_redirect = 1'b0;
        n_checks++;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL stale_redirect_req got=%0b exp=0", s_req_valid); end
        got = 1'b0; first_i = -1; stale = 0; first_pc = 32'h0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (s_out_valid && s_out_pc < 32'h100) stale++;
            if (s_out_valid && !got) begin got = 1'b1; first_i = i; first_pc = s_out_pc; end
        end
        n_checks += 3;
        if (first_pc !== 32'h100) begin n_fail++; $display("FAIL stale_first_pc got=%h exp=00000100", first_pc); end
        if (stale != 0) begin n_fail++; $display("FAIL stale_seen got=%0d exp=0", stale); end
        if (first_i != 4) begin n_fail++; $display("FAIL stale_latency got=%0d exp=4", first_i); end
    endtask

    task automatic test_redirect_collision();
        do_reset();
        set_knobs(100, 100, 1, 1);
        repeat (5) cycle();
        g_redirect = 1'b1;
        g_redirect_pc = 32'h0000_2003;
        cycle();
        g_redirect = 1'b0;
        n_checks += 2;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL coll_req got=%0b exp=0", s_req_valid); end
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_pop got=%0b exp=0", s_out_valid); end
        cycle();
        n_checks += 2;
        if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_empty got=%0b exp=0", s_out_valid); end
        if (!(s_req_valid === 1'b1 && s_req_addr === 32'h2000)) begin
            n_fail++;
            $display("FAIL coll_restart got=%0b/%h exp=1/00002000", s_req_valid, s_req_addr);
        end
        cycle();
        cycle();
        n_checks++;
        if (!(s_out_valid === 1'b1 && s_out_pc === 32'h2000)) begin
            n_fail++;
            $display("FAIL coll_first_out got=%0b/%h exp=1/00002000", s_out_valid, s_out_pc);
        end
        repeat (4) cycle();
    endtask

    task automatic test_back_to_back();
        bit          got;
        logic [31:0] first_pc;
        do_reset();
        set_knobs(100, 100, 2, 2);
        repeat (3) cycle();
        g_redirect = 1'b1;
        g_redirect_pc = 32'h400;
        cycle();
        g_redirect_pc = 32'h801;
        cycle();
        g_redirect = 1'b0;
        got = 1'b0; first_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_out_valid && !got) begin got = 1'b1; first_pc = s_out_pc; end
        end
        n_checks++;
        if (first_pc !== 32'h800) begin n_fail++; $display("FAIL b2b_first_pc got=%h exp=00000800", first_pc); end
    endtask

    task automatic test_illegal();
        logic [31:0] e_instr;
        logic        e_ill;
`ifdef FETCH_ENCODING_CHECK_EN
        e_instr = 32'h0000_0013;
        e_ill   = 1'b1;
`else
        e_instr = 32'h0000_0000;
        e_ill   = 1'b0;
`endif
        do_reset();
        g_zero8 = 1'b1;
        set_knobs(100, 100, 1, 1);
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i == 4) begin
                n_checks++;
                if (!(s_out_valid === 1'b1 && s_out_pc === 32'h8 &&
                      s_out_instr === e_instr && s_out_ill === e_ill)) begin
                    n_fail++;
                    $display("FAIL illegal_word got=%0b/%h/%h/%0b exp=1/00000008/%h/%0b",
                             s_out_valid, s_out_pc, s_out_instr, s_out_ill, e_instr, e_ill);
                end
            end
        end
        g_zero8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_knobs(100, 0, 1, 1);
        repeat (3) cycle();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%0b exp=1", out_valid); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async got=%0b exp=0", out_valid); end
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        set_knobs(100, 100, 1, 1);
        cycle();
        n_checks++;
        if (!(s_req_valid === 1'b1 && s_req_addr === RESET_PC)) begin
            n_fail++;
            $display("FAIL mid_restart got=%0b/%h exp=1/%h", s_req_valid, s_req_addr, RESET_PC);
        end
        repeat (6) cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            set_knobs($urandom_range(100, 40), $urandom_range(100, 20), 1, $urandom_range(4, 1));
            for (int i = 0; i < 250; i++) begin
                g_redirect = g_redirect ? roll(40) : roll(3);
                if (roll(15)) g_redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else          g_redirect_pc = $urandom;
                cycle();
            end
        end
        g_redirect = 1'b0;
        set_knobs(100, 100, 1, 1);
        repeat (20) cycle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_collision();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
